// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// The optional scoreboard is enabled by defining REGFILE_SCOREBOARD_EN.
package regfile_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

  function automatic int rf_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_clr_ctrl.sv
// Post-reset clear engine: walks every register address once, then raises ready.
// Holds the pipeline off until the whole array is known to be zero.
module regfile_clr_ctrl
  import regfile_pkg::*;
#(
  parameter int NREGS = RF_NREGS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       ready,
  output logic                       clr_we,
  output logic [rf_aw(NREGS)-1:0]    clr_addr
);

  localparam int AW = rf_aw(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_t     state;
  logic [AW-1:0] clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RF_CLEAR;
      clr_cnt <= '0;
    end else if (state == RF_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == LAST) state <= RF_READY;
    end
  end

  assign ready    = (state == RF_READY);
  assign clr_we   = (state == RF_CLEAR);
  assign clr_addr = clr_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write-to-read bypass and a post-reset clear engine.
// Define REGFILE_SCOREBOARD_EN to add per-register busy tracking (sb_set/sb_addr/rbusy).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NWR-1:0]                       we,
  input  logic [NWR-1:0][rf_aw(NREGS)-1:0]     waddr,
  input  logic [NWR-1:0][XLEN-1:0]             wdata,
  input  logic [NRD-1:0][rf_aw(NREGS)-1:0]     raddr,
  output logic [NRD-1:0][XLEN-1:0]             rdata,
  output logic                                 ready
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                                 sb_set,
  input  logic [rf_aw(NREGS)-1:0]              sb_addr,
  output logic [NRD-1:0]                       rbusy
`endif
);

  localparam int AW = rf_aw(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic            clr_we;
  logic [AW-1:0]   clr_addr;

  regfile_clr_ctrl #(.NREGS(NREGS)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  function automatic logic wr_ok(input logic en, input logic [AW-1:0] wa);
    return en && !((ZERO_REG != 0) && (wa == '0));
  endfunction

  function automatic logic wr_hit(input logic en, input logic [AW-1:0] wa,
                                  input logic [AW-1:0] ra);
    return wr_ok(en, wa) && (wa == ra);
  endfunction

  // Ports are visited in ascending order so the highest-index writer lands last.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_addr] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok(we[j], waddr[j])) regs[waddr[j]] <= wdata[j];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [XLEN-1:0] val;

    always_comb begin
      val = regs[raddr[i]];
      for (int j = 0; j < NWR; j++) begin
        if (wr_hit(we[j], waddr[j], raddr[i])) val = wdata[j];
      end
      if (((ZERO_REG != 0) && (raddr[i] == '0)) || !ready) val = '0;
    end

    assign rdata[i] = val;
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREGS-1:0] busy;

  // A new producer marked in the same cycle as a retiring write keeps the register busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (ready) begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j]) busy[waddr[j]] <= 1'b0;
      end
      if (sb_set) busy[sb_addr] <= 1'b1;
      if (ZERO_REG != 0) busy[0] <= 1'b0;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_sb
    logic hit;

    always_comb begin
      hit = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_hit(we[j], waddr[j], raddr[i])) hit = 1'b1;
      end
    end

    assign rbusy[i] = ready && busy[raddr[i]] && !hit &&
                      !((ZERO_REG != 0) && (raddr[i] == '0));
  end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp at default parameters.
// Scoreboard checks are compiled in when REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_mp;

  logic             clk;
  logic             rst_n;
  logic [1:0]       we;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;
  logic [1:0][4:0]  raddr;
  logic [1:0][31:0] rdata;
  logic             ready;
`ifdef REGFILE_SCOREBOARD_EN
  logic             sb_set;
  logic [4:0]       sb_addr;
  logic [1:0]       rbusy;
`endif

  int vec_count  = 0;
  int miss_count = 0;

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr   (raddr),
    .rdata   (rdata),
    .ready   (ready)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .rbusy   (rbusy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] w_en,
                               input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    we       = w_en;
    waddr[0] = wa0;
    wdata[0] = wd0;
    waddr[1] = wa1;
    wdata[1] = wd1;
    raddr[0] = ra0;
    raddr[1] = ra1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    we    = '0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
`ifdef REGFILE_SCOREBOARD_EN
    sb_set  = 1'b0;
    sb_addr = '0;
`endif
    #12;
    checkOutput("reset_ready", {31'b0, ready}, 32'd0);
    checkOutput("reset_rdata0", rdata[0], 32'd0);

    // Clear interrupted by a second reset ten cycles in
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    checkOutput("clr10_ready", {31'b0, ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", {31'b0, ready}, 32'd0);
    tick();
    rst_n = 1'b1;

    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 10) begin
`ifdef REGFILE_SCOREBOARD_EN
        sb_set  = 1'b1;
        sb_addr = 5'd4;
`endif
        applyStimulus(2'b01, 5'd2, 32'hBEEF_0001, 5'd0, 32'd0, 5'd2, 5'd31);
        checkOutput("clr_rd_bypass", rdata[0], 32'd0);
        checkOutput("clr_rd31", rdata[1], 32'd0);
      end
      if (k == 12) begin
`ifdef REGFILE_SCOREBOARD_EN
        sb_set = 1'b0;
`endif
        applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0);
      end
      if (k == 1)  checkOutput("clr1_ready", {31'b0, ready}, 32'd0);
      if (k == 31) checkOutput("clr31_ready", {31'b0, ready}, 32'd0);
      if (k == 32) checkOutput("clr32_ready", {31'b0, ready}, 32'd1);
    end

    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd2, 5'd31);
    checkOutput("clr_ignored_x2", rdata[0], 32'd0);
    checkOutput("cleared_x31", rdata[1], 32'd0);
`ifdef REGFILE_SCOREBOARD_EN
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 5'd4);
    checkOutput("clr_sb_ignored", {31'b0, rbusy[0]}, 32'd0);
`endif

    applyStimulus(2'b01, 5'd5, 32'hAAAA_0000, 5'd0, 32'd0, 5'd5, 5'd0);
    checkOutput("byp_x5", rdata[0], 32'hAAAA_0000);
    tick();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 5'd0);
    checkOutput("reg_x5", rdata[0], 32'hAAAA_0000);

    applyStimulus(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 5'd7, 5'd7);
    checkOutput("byp_x7_p0", rdata[0], 32'h22);
    checkOutput("byp_x7_p1", rdata[1], 32'h22);
    tick();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 5'd7);
    checkOutput("reg_x7_p0", rdata[0], 32'h22);
    checkOutput("reg_x7_p1", rdata[1], 32'h22);

    applyStimulus(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    checkOutput("byp_x0", rdata[0], 32'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0);
    checkOutput("reg_x0", rdata[1], 32'd0);

    applyStimulus(2'b11, 5'd10, 32'h1234, 5'd11, 32'h5678, 5'd10, 5'd11);
    checkOutput("byp_x10", rdata[0], 32'h1234);
    checkOutput("byp_x11", rdata[1], 32'h5678);
    tick();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd10, 5'd11);
    checkOutput("reg_x10", rdata[0], 32'h1234);
    checkOutput("reg_x11", rdata[1], 32'h5678);
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 5'd5);
    checkOutput("hold_x7", rdata[0], 32'h22);
    checkOutput("hold_x5", rdata[1], 32'hAAAA_0000);

`ifdef REGFILE_SCOREBOARD_EN
    sb_set  = 1'b1;
    sb_addr = 5'd9;
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd9);
    checkOutput("sb9_pre", {31'b0, rbusy[0]}, 32'd0);
    tick();
    sb_set = 1'b0;
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd9);
    checkOutput("sb9_busy_p0", {31'b0, rbusy[0]}, 32'd1);
    checkOutput("sb9_busy_p1", {31'b0, rbusy[1]}, 32'd1);
    applyStimulus(2'b10, 5'd0, 32'd0, 5'd9, 32'h99, 5'd9, 5'd0);
    checkOutput("sb9_byp_busy", {31'b0, rbusy[0]}, 32'd0);
    checkOutput("sb9_byp_data", rdata[0], 32'h99);
    tick();
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd9);
    checkOutput("sb9_cleared", {31'b0, rbusy[1]}, 32'd0);

    sb_set  = 1'b1;
    sb_addr = 5'd3;
    applyStimulus(2'b01, 5'd3, 32'h33, 5'd0, 32'd0, 5'd0, 5'd3);
    tick();
    sb_set = 1'b0;
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd3);
    checkOutput("sb3_setwins", {31'b0, rbusy[1]}, 32'd1);
    checkOutput("sb3_data", rdata[1], 32'h33);

    sb_set  = 1'b1;
    sb_addr = 5'd0;
    tick();
    sb_set = 1'b0;
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd3);
    checkOutput("sb0_never", {31'b0, rbusy[0]}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
